// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchronizer, mid-bit sampling FSM and a
// one-byte output buffer with valid/ready handshake, framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic [7:0]    shift;

    // Line synchronizer; resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    timer <= '0;
                    idx   <= '0;
                    if (!rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                // Half-bit check re-centres all later samples in the middle of each bit.
                START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (timer == FULL_LAST) begin
                        timer      <= '0;
                        shift[idx] <= rxs;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                // A completing byte may also complete the handshake on the same cycle.
                STOP: begin
                    if (timer == FULL_LAST) begin
                        timer <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx;

    localparam int unsigned C = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: the line as seen two edges late, decoded by bit-centre arithmetic.
    logic [7:0] m_data, m_byte;
    logic       m_valid, m_ferr, m_ovr, m_busy;
    logic       d1, d2, seen, hs, vb;
    int         m_mode, m_k;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data = 8'h00; m_byte = 8'h00;
            m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
            m_mode = 0; m_k = 0; d1 = 1'b1; d2 = 1'b1;
        end else begin
            seen = d2; d2 = d1; d1 = rxd;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            vb = m_valid;
            hs = m_valid && rx_ready;
            if (hs) m_valid = 1'b0;
            case (m_mode)
                0: if (!seen) begin m_mode = 1; m_k = 0; m_busy = 1'b1; end
                1: begin
                    m_k++;
                    if (m_k == C / 2) begin
                        if (seen) begin m_mode = 0; m_busy = 1'b0; end
                    end else if (m_k > C / 2 && m_k < C / 2 + 9 * C && (m_k - C / 2) % C == 0) begin
                        m_byte[(m_k - C / 2) / C - 1] = seen;
                    end else if (m_k == C / 2 + 9 * C) begin
                        if (seen) begin
                            m_mode = 0; m_busy = 1'b0;
                            if (!vb || hs) begin m_data = m_byte; m_valid = 1'b1; end
                            else m_ovr = 1'b1;
                        end else begin
                            m_ferr = 1'b1; m_mode = 2;
                        end
                    end
                end
                default: if (seen) begin m_mode = 0; m_busy = 1'b0; end
            endcase
        end
    end

    always @(negedge clk)
        chk("outputs_vs_model", {20'd0, rx_data, rx_valid, frame_err, overrun, busy},
            {20'd0, m_data, m_valid, m_ferr, m_ovr, m_busy});

    // Observed-event counters used by the literal checks.
    int   n_ferr = 0, n_ovr = 0, n_rise = 0, last_rise = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (rx_valid && !prev_valid) begin n_rise++; last_rise = cyc; end
        prev_valid = rx_valid;
    end

    // Drives one frame starting just after the next edge; cut >= 0 abandons it early.
    task automatic send(input logic [7:0] b, input logic stopv, input int cut);
        logic [9:0] fr;
        fr = {stopv, b, 1'b0};
        @(posedge clk); #1;
        t0 = cyc;
        for (int k = 0; k < 10 * C; k++) begin
            if (k == cut) return;
            if (k % C == 0) rxd = fr[k / C];
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        int         f0, o0, r0, r, lat;
        logic [7:0] rb;
        logic       done;
        reset = 1'b1; rxd = 1'b1; rx_ready = 1'b0; done = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("reset_state", {rx_data, rx_valid, frame_err, overrun, busy}, 32'h0);
        reset = 1'b0;
        repeat (5) @(posedge clk); #1;

        // 0xA5, latency and hold until handshake
        r0 = n_rise;
        send(8'hA5, 1'b1, -1);
        lat = last_rise - t0;
        chk("a5_rise_once", n_rise - r0, 1);
        chk("a5_latency_in_154_156", (lat >= 154 && lat <= 156), 1);
        chk("a5_data", rx_data, 8'hA5);
        repeat (20) @(posedge clk); #1;
        chk("a5_held_valid", rx_valid, 1);
        pulse_ready();
        chk("a5_valid_cleared", rx_valid, 0);
        chk("a5_data_retained", rx_data, 8'hA5);

        // short low glitch
        f0 = n_ferr; r0 = n_rise;
        rxd = 1'b0;
        repeat (5) @(posedge clk); #1;
        rxd = 1'b1;
        chk("glitch_start_seen", busy, 1);
        repeat (20) @(posedge clk); #1;
        chk("glitch_busy_back", busy, 0);
        chk("glitch_no_valid", n_rise - r0, 0);
        chk("glitch_no_ferr", n_ferr - f0, 0);

        // 0x3C with low stop bit, line held low
        f0 = n_ferr; r0 = n_rise;
        send(8'h3C, 1'b0, -1);
        repeat (40) @(posedge clk); #1;
        chk("ferr_one_pulse", n_ferr - f0, 1);
        chk("ferr_no_valid", n_rise - r0, 0);
        chk("ferr_busy_in_break", busy, 1);
        rxd = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("ferr_busy_released", busy, 0);

        // back-to-back without handshake -> overrun
        o0 = n_ovr;
        send(8'h11, 1'b1, -1);
        send(8'h22, 1'b1, -1);
        repeat (5) @(posedge clk); #1;
        chk("ovr_data_kept", rx_data, 8'h11);
        chk("ovr_one_pulse", n_ovr - o0, 1);

        // handshake on the completing cycle -> new byte loads, no overrun
        o0 = n_ovr;
        fork
            send(8'h22, 1'b1, -1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk); #1;
                rx_ready = 1'b0;
            end
        join
        chk("hs_data_new", rx_data, 8'h22);
        chk("hs_valid_kept", rx_valid, 1);
        chk("hs_no_overrun", n_ovr - o0, 0);
        pulse_ready();

        // reset mid data bit 4 of 0xFF
        f0 = n_ferr; o0 = n_ovr; r0 = n_rise;
        send(8'hFF, 1'b1, 88);
        chk("mid_frame_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("async_reset_clear", {rx_data, rx_valid, frame_err, overrun, busy}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        rxd = 1'b1;
        repeat (200) @(posedge clk); #1;
        chk("partial_no_events", (n_rise - r0) + (n_ferr - f0) + (n_ovr - o0), 0);
        send(8'h5A, 1'b1, -1);
        repeat (3) @(posedge clk); #1;
        chk("after_reset_data", rx_data, 8'h5A);
        chk("after_reset_valid", rx_valid, 1);
        pulse_ready();

        // reset released with line already low: start on third edge
        reset = 1'b1; rxd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        r = cyc;
        @(posedge clk); @(posedge clk); #1;
        chk("refill_not_yet", busy, 0);
        @(posedge clk); #1;
        chk("refill_start_edge3", busy, 1);
        rb = 8'hC3;
        repeat (C - 3) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rxd = rb[i];
            repeat (C) @(posedge clk); #1;
        end
        rxd = 1'b1;
        repeat (C) @(posedge clk); #1;
        chk("refill_frame_data", rx_data, 8'hC3);
        chk("refill_frame_valid", rx_valid, 1);
        pulse_ready();

        // extremes
        f0 = n_ferr;
        send(8'h00, 1'b1, -1);
        repeat (3) @(posedge clk); #1;
        chk("byte_00", rx_data, 8'h00);
        chk("byte_00_valid", rx_valid, 1);
        pulse_ready();
        send(8'hFF, 1'b1, -1);
        repeat (3) @(posedge clk); #1;
        chk("byte_ff", rx_data, 8'hFF);
        chk("extremes_no_ferr", n_ferr - f0, 0);
        pulse_ready();

        // randomized traffic, checked every cycle by the model
        fork
            begin
                for (int n = 0; n < 20; n++) begin
                    repeat ($urandom_range(0, 20)) @(posedge clk);
                    #1;
                    if ($urandom_range(0, 5) == 0) begin
                        rxd = 1'b0;
                        repeat ($urandom_range(1, 6)) @(posedge clk);
                        #1 rxd = 1'b1;
                    end else begin
                        rb = 8'($urandom);
                        send(rb, ($urandom_range(0, 5) != 0), -1);
                        if (!rxd) begin
                            repeat ($urandom_range(1, 30)) @(posedge clk);
                            #1 rxd = 1'b1;
                        end
                    end
                end
                repeat (50) @(posedge clk);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rx_ready = ($urandom_range(0, 3) == 0);
                end
            end
        join
        rx_ready = 1'b0;
        repeat (10) @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per bit (100 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state rising-edge triggered.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rxd  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 SHALL have port rx_ready  input  1  consumer accepts rx_data when high together with rx_valid.
REQ-006 SHALL have port rx_data  output  8  last received byte; stable while rx_valid is high.
REQ-007 SHALL have port rx_valid  output  1  a byte is held and awaiting rx_ready.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: good byte completed while rx_valid was still high.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer, reset to 1; all internal use of the line SHALL see only the synchronized value rxs.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: rxs==0 -> START; clear bit-timer; clear bit index.
REQ-014 START: after CLKS_PER_BIT/2 cycles, sample rxs; 0 -> DATA with timer cleared; 1 -> IDLE (glitch rejected, no outputs pulsed).
REQ-015 DATA: every CLKS_PER_BIT cycles, sample rxs into shift register bit[index], index 0..7 (LSB first); after index 7 -> STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, sample rxs; 1 -> byte good, -> IDLE; 0 -> pulse frame_err, discard byte, -> BREAK.
REQ-017 BREAK: remain until rxs==1, then -> IDLE; no new start is detected while in BREAK.
REQ-018 Bit timer SHALL be a counter of ceil(log2(CLKS_PER_BIT)) bits, wrapping to 0 at CLKS_PER_BIT-1; no drift across the frame.
REQ-019 Good byte, rx_valid low: on the cycle after the stop sample, rx_data <= shift register and rx_valid <= 1.
REQ-020 Good byte, rx_valid high, no handshake that cycle: rx_data unchanged, byte dropped, overrun pulsed one cycle.
REQ-021 Good byte coinciding with rx_valid&&rx_ready: handshake completes and new byte loads; rx_valid stays 1; no overrun.
REQ-022 rx_valid&&rx_ready without a new byte: rx_valid <= 0 next cycle; rx_data retains its value.
REQ-023 rx_ready while rx_valid is low SHALL have no effect.
REQ-024 Receiver SHALL continue receiving while rx_valid is high (one-byte buffer plus shift register).
REQ-025 Latency: falling edge at rxd pin to rx_valid rise = 2 (sync) + 9.5*CLKS_PER_BIT + 1 cycles, within +-1 cycle.

Reset
REQ-026 Asserting reset at any time, including mid-frame, SHALL immediately force: state IDLE, synchronizer flops 1, timer 0, index 0, shift register 0x00, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, busy 0.
REQ-027 After reset deasserts with rxd held low, the block SHALL enter START on the third rising edge (synchronizer refill) and process the frame normally.
REQ-028 A partial frame interrupted by reset SHALL never produce rx_valid, frame_err or overrun.

Verification (CLKS_PER_BIT=16, clk 10 ns)
REQ-029 Send 0xA5 8N1, rx_ready=0 -> rx_valid rises within 155+-1 cycles of start edge, rx_data=0xA5, held until rx_ready pulse, then rx_valid=0.
REQ-030 Low glitch of 5 cycles on idle rxd -> START entered, returns to IDLE, rx_valid/frame_err stay 0, busy returns 0.
REQ-031 Send 0x3C with stop bit driven 0, then hold low 40 cycles -> frame_err one-cycle pulse, rx_valid 0, busy stays 1 until rxd high, then 0.
REQ-032 Send 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11, overrun pulses once at end of second frame; repeat with rx_ready=1 on the cycle 0x22 completes -> rx_data=0x22, rx_valid stays 1, no overrun.
REQ-033 Assert reset for 2 cycles at mid data bit 4 of 0xFF -> all outputs 0 immediately; no rx_valid; next frame 0x5A received correctly.
REQ-034 Send 0x00 and 0xFF -> rx_data 0x00 and 0xFF respectively, no frame_err.
